// File: rtl/riscv_pkg.sv
// Shared LSU definitions: RV32 funct3 codes, FSM state encoding and the byte-lane shift helper.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRmw
    } lsu_state_e;

    // Bit offset of the byte lane selected by addr[1:0].
    function automatic logic [4:0] lane_shift(input logic [1:0] lane);
        return {lane, 3'b000};
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge into a RAM word.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_data_o
);

    logic [4:0]  shift;
    logic [31:0] shifted;
    logic [31:0] size_mask;

    always_comb begin
        shift   = lane_shift(lane_i);
        shifted = rdata_i >> shift;

        load_data_o = '0;
        case (funct3_i)
            F3_B:    load_data_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_data_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    load_data_o = shifted;
            F3_BU:   load_data_o = {24'b0, shifted[7:0]};
            F3_HU:   load_data_o = {16'b0, shifted[15:0]};
            default: load_data_o = '0;
        endcase

        case (funct3_i)
            F3_B:    size_mask = 32'h0000_00ff;
            F3_H:    size_mask = 32'h0000_ffff;
            default: size_mask = 32'hffff_ffff;
        endcase

        // Keep the untouched lanes of the old word, drop the new bytes into the selected lane.
        store_data_o = (rdata_i & ~(size_mask << shift)) | ((wdata_i & size_mask) << shift);
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// RV32 load/store controller for a word-wide RAM without byte enables (sub-word stores use RMW).
// Optional LSU_RANGE_CHECK_EN: byte addresses beyond the RAM produce an error response.
module lsu_mem_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [31:0]           req_addr_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  ram_w_en_o,
    output logic [ADDR_WIDTH-1:0] ram_w_addr_o,
    output logic [DATA_WIDTH-1:0] ram_w_data_o,
    output logic                  ram_r_en_o,
    output logic [ADDR_WIDTH-1:0] ram_r_addr_o,
    input  logic [DATA_WIDTH-1:0] ram_r_data_i
);

    lsu_state_e state_q, state_d;

    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            lane_q, lane_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;

    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [ADDR_WIDTH-1:0] req_word;
    logic                  req_bad_f3;
    logic                  req_misaligned;
    logic                  req_oor;
    logic                  req_err;
    logic [31:0]           load_data;
    logic [31:0]           store_data;

    assign req_word = req_addr_i[ADDR_WIDTH+1:2];

`ifdef LSU_RANGE_CHECK_EN
    assign req_oor = |req_addr_i[31:ADDR_WIDTH+2];
`else
    logic unused_addr_hi;
    assign req_oor        = 1'b0;
    assign unused_addr_hi = ^req_addr_i[31:ADDR_WIDTH+2];
`endif

    always_comb begin
        req_bad_f3     = 1'b0;
        req_misaligned = 1'b0;
        case (req_funct3_i)
            F3_B:    req_bad_f3 = 1'b0;
            F3_H:    req_misaligned = req_addr_i[0];
            F3_W:    req_misaligned = |req_addr_i[1:0];
            F3_BU:   req_bad_f3 = req_we_i;
            F3_HU: begin
                req_bad_f3     = req_we_i;
                req_misaligned = req_addr_i[0];
            end
            default: req_bad_f3 = 1'b1;
        endcase
        req_err = req_bad_f3 | req_misaligned | req_oor;
    end

    lsu_align u_align (
        .funct3_i     (funct3_q),
        .lane_i       (lane_q),
        .rdata_i      (ram_r_data_i),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .store_data_o (store_data)
    );

    always_comb begin
        state_d      = state_q;
        funct3_d     = funct3_q;
        lane_d       = lane_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = '0;
        rsp_err_d    = 1'b0;
        req_ready_o  = 1'b0;
        ram_w_en_o   = 1'b0;
        ram_w_addr_o = addr_q;
        ram_w_data_o = store_data;
        ram_r_en_o   = 1'b0;
        ram_r_addr_o = addr_q;

        unique case (state_q)
            StIdle: begin
                req_ready_o  = !rst;
                ram_w_addr_o = req_word;
                ram_w_data_o = req_wdata_i;
                ram_r_addr_o = req_word;
                if (req_valid_i && !rst) begin
                    if (req_err) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (req_we_i && (req_funct3_i == F3_W)) begin
                        ram_w_en_o  = 1'b1;
                        rsp_valid_d = 1'b1;
                    end else begin
                        ram_r_en_o = 1'b1;
                        funct3_d   = req_funct3_i;
                        lane_d     = req_addr_i[1:0];
                        addr_d     = req_word;
                        wdata_d    = req_wdata_i;
                        state_d    = req_we_i ? StRmw : StLoad;
                    end
                end
            end
            StLoad: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = load_data;
                state_d     = StIdle;
            end
            StRmw: begin
                // Gated by rst so a reset landing mid-RMW never writes a half-merged word.
                ram_w_en_o  = !rst;
                rsp_valid_d = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            funct3_q    <= '0;
            lane_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            funct3_q    <= funct3_d;
            lane_q      <= lane_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed vector table, reset-abort sequence and random traffic
// against a byte-array reference memory.
module tb_lsu_mem_ctrl;

    localparam int unsigned AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid_i;
    logic          req_ready_o;
    logic          req_we_i;
    logic [2:0]    req_funct3_i;
    logic [31:0]   req_addr_i;
    logic [31:0]   req_wdata_i;
    logic          rsp_valid_o;
    logic [31:0]   rsp_rdata_o;
    logic          rsp_err_o;
    logic          ram_w_en_o;
    logic [AW-1:0] ram_w_addr_o;
    logic [31:0]   ram_w_data_o;
    logic          ram_r_en_o;
    logic [AW-1:0] ram_r_addr_o;
    logic [31:0]   ram_r_data_i = 32'h0;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_funct3_i (req_funct3_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .ram_w_en_o   (ram_w_en_o),
        .ram_w_addr_o (ram_w_addr_o),
        .ram_w_data_o (ram_w_data_o),
        .ram_r_en_o   (ram_r_en_o),
        .ram_r_addr_o (ram_r_addr_o),
        .ram_r_data_i (ram_r_data_i)
    );

    // Word RAM: registered read, zero when not enabled, old data on same-cycle read/write.
    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_w_en_o) mem[ram_w_addr_o] <= ram_w_data_o;
        ram_r_data_i <= ram_r_en_o ? mem[ram_r_addr_o] : 32'h0;
    end

    int wen_cnt = 0;
    int ren_cnt = 0;
    int rsp_cnt = 0;
    always @(negedge clk) begin
        if (ram_w_en_o) wen_cnt = wen_cnt + 1;
        if (ram_r_en_o) ren_cnt = ren_cnt + 1;
        if (rsp_valid_o) rsp_cnt = rsp_cnt + 1;
    end

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt = chk_cnt + 1;
        if (act === exp) pass_cnt = pass_cnt + 1;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference: byte-addressed memory covering the aliased 2^(AW+2)-byte space.
    logic [7:0] ref_mem [0:(1<<(AW+2))-1];

    function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic e;
        case (f3)
            3'b000:  e = 1'b0;
            3'b001:  e = a[0];
            3'b010:  e = (a[1:0] != 2'b00);
            3'b100:  e = we;
            3'b101:  e = we | a[0];
            default: e = 1'b1;
        endcase
`ifdef LSU_RANGE_CHECK_EN
        if ((a >> (AW + 2)) != 0) e = 1'b1;
`endif
        return e;
    endfunction

    function automatic int ref_lat(input logic we, input logic [2:0] f3, input logic [31:0] a);
        if (ref_err(we, f3, a)) return 1;
        if (we && f3 == 3'b010) return 1;
        return 2;
    endfunction

    task automatic ref_apply(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, output logic [31:0] rd);
        int idx;
        int nbytes;
        logic [31:0] v;
        rd = 32'h0;
        if (ref_err(we, f3, a)) return;
        idx    = int'(a % (32'd1 << (AW + 2)));
        nbytes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        if (we) begin
            for (int k = 0; k < nbytes; k++) ref_mem[idx+k] = 8'(wd >> (8 * k));
        end else begin
            v = 32'h0;
            for (int k = 0; k < nbytes; k++) v = v + (32'(ref_mem[idx+k]) << (8 * k));
            if (f3 == 3'b000 && v >= 32'h80) v = v + 32'hFFFF_FF00;
            if (f3 == 3'b001 && v >= 32'h8000) v = v + 32'hFFFF_0000;
            rd = v;
        end
    endtask

    task automatic run(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                       input int exp_lat);
        int   lat;
        logic got;
        logic [31:0] rd;
        logic er;
        logic rdy;
        int   exp_w;
        int   exp_r;
        wen_cnt      = 0;
        ren_cnt      = 0;
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_funct3_i = f3;
        req_addr_i   = a;
        req_wdata_i  = wd;
        @(negedge clk);
        chk({tag, " ready"}, 32'(req_ready_o), 32'd1);
        chk({tag, " rsp_idle"}, 32'(rsp_valid_o), 32'd0);
        @(posedge clk);
        #1;
        req_valid_i  = 1'b0;
        req_we_i     = 1'($urandom);
        req_funct3_i = 3'($urandom);
        req_addr_i   = $urandom;
        req_wdata_i  = $urandom;
        got = 1'b0;
        lat = 0;
        rd  = 32'h0;
        er  = 1'b0;
        rdy = 1'b0;
        while (!got && lat < 6) begin
            @(negedge clk);
            lat = lat + 1;
            if (rsp_valid_o) begin
                got = 1'b1;
                rd  = rsp_rdata_o;
                er  = rsp_err_o;
                rdy = req_ready_o;
            end
        end
        if (!got) begin
            chk({tag, " rsp_timeout"}, 32'(lat), 32'(exp_lat));
        end else begin
            chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
            chk({tag, " rdata"}, rd, exp_rd);
            chk({tag, " err"}, 32'(er), 32'(exp_err));
            chk({tag, " ready_at_rsp"}, 32'(rdy), 32'd1);
        end
        @(posedge clk);
        #1;
        exp_w = (!exp_err && we) ? 1 : 0;
        exp_r = (!exp_err && !(we && f3 == 3'b010)) ? 1 : 0;
        chk({tag, " w_en_count"}, 32'(wen_cnt), 32'(exp_w));
        chk({tag, " r_en_count"}, 32'(ren_cnt), 32'(exp_r));
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        err;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;

        for (int i = 0; i < (1 << (AW + 2)); i++) ref_mem[i] = 8'h0;

        rst          = 1'b1;
        req_valid_i  = 1'b1;
        req_we_i     = 1'b1;
        req_funct3_i = 3'b010;
        req_addr_i   = 32'h40;
        req_wdata_i  = 32'h1234_5678;
        repeat (2) @(negedge clk);
        chk("reset ready", 32'(req_ready_o), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("reset rdata", rsp_rdata_o, 32'h0);
        chk("reset err", 32'(rsp_err_o), 32'd0);
        chk("reset w_en", 32'(ram_w_en_o), 32'd0);
        chk("reset r_en", 32'(ram_r_en_o), 32'd0);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        req_valid_i = 1'b0;
        @(posedge clk);
        #1;

        tbl.push_back('{"sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1});
        tbl.push_back('{"lw_10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2});
        tbl.push_back('{"sw_10b", 1'b1, 3'b010, 32'h10, 32'h11223344, 32'h0, 1'b0, 1});
        tbl.push_back('{"sb_13", 1'b1, 3'b000, 32'h13, 32'h000000A5, 32'h0, 1'b0, 2});
        tbl.push_back('{"lw_after_sb", 1'b0, 3'b010, 32'h10, 32'h0, 32'hA5223344, 1'b0, 2});
        tbl.push_back('{"lb_13", 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFA5, 1'b0, 2});
        tbl.push_back('{"lbu_13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000A5, 1'b0, 2});
        tbl.push_back('{"sh_12", 1'b1, 3'b001, 32'h12, 32'h00008001, 32'h0, 1'b0, 2});
        tbl.push_back('{"lw_after_sh", 1'b0, 3'b010, 32'h10, 32'h0, 32'h80013344, 1'b0, 2});
        tbl.push_back('{"lh_12", 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF8001, 1'b0, 2});
        tbl.push_back('{"lhu_12", 1'b0, 3'b101, 32'h12, 32'h0, 32'h00008001, 1'b0, 2});
        tbl.push_back('{"lb_11", 1'b0, 3'b000, 32'h11, 32'h0, 32'h00000033, 1'b0, 2});
        tbl.push_back('{"lh_10", 1'b0, 3'b001, 32'h10, 32'h0, 32'h00003344, 1'b0, 2});
        tbl.push_back('{"lw_11_misal", 1'b0, 3'b010, 32'h11, 32'h0, 32'h0, 1'b1, 1});
        tbl.push_back('{"sh_13_misal", 1'b1, 3'b001, 32'h13, 32'hFFFF, 32'h0, 1'b1, 1});
        tbl.push_back('{"f3_011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1});
        tbl.push_back('{"sbu_illegal", 1'b1, 3'b100, 32'h10, 32'h77, 32'h0, 1'b1, 1});
        tbl.push_back('{"sw_0", 1'b1, 3'b010, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0, 1});
`ifdef LSU_RANGE_CHECK_EN
        tbl.push_back('{"lw_4000", 1'b0, 3'b010, 32'h4000, 32'h0, 32'h0, 1'b1, 1});
`else
        tbl.push_back('{"lw_4000", 1'b0, 3'b010, 32'h4000, 32'h0, 32'hCAFEF00D, 1'b0, 2});
`endif

        foreach (tbl[i]) begin
            ref_apply(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, rd);
            run(tbl[i].name, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
                tbl[i].rd, tbl[i].err, tbl[i].lat);
        end

        // Reset asserted in the RMW cycle of SB 0x20 must abort it without a write or response.
        ref_apply(1'b1, 3'b010, 32'h20, 32'h55667788, rd);
        run("sw_20", 1'b1, 3'b010, 32'h20, 32'h55667788, 32'h0, 1'b0, 1);
        req_valid_i  = 1'b1;
        req_we_i     = 1'b1;
        req_funct3_i = 3'b000;
        req_addr_i   = 32'h20;
        req_wdata_i  = 32'h99;
        @(negedge clk);
        chk("abort ready", 32'(req_ready_o), 32'd1);
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        rst         = 1'b1;
        wen_cnt     = 0;
        rsp_cnt     = 0;
        @(negedge clk);
        chk("abort w_en", 32'(ram_w_en_o), 32'd0);
        chk("abort ready_in_rst", 32'(req_ready_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort ready_after", 32'(req_ready_o), 32'd1);
        @(posedge clk);
        #1;
        chk("abort w_en_count", 32'(wen_cnt), 32'd0);
        chk("abort rsp_count", 32'(rsp_cnt), 32'd0);
        ref_apply(1'b0, 3'b010, 32'h20, 32'h0, rd);
        run("lw_20_after_abort", 1'b0, 3'b010, 32'h20, 32'h0, rd, 1'b0, 2);

        for (int w = 0; w < 64; w++) begin
            wd = $urandom;
            ref_apply(1'b1, 3'b010, 32'(w * 4), wd, rd);
            run("fill", 1'b1, 3'b010, 32'(w * 4), wd, 32'h0, 1'b0, 1);
        end

        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom);
            case ($urandom_range(0, 9))
                0, 1:    f3 = 3'b000;
                2, 3:    f3 = 3'b001;
                4, 5:    f3 = 3'b010;
                6:       f3 = 3'b100;
                7:       f3 = 3'b101;
                default: f3 = 3'($urandom);
            endcase
            a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFF_C000);
            wd = $urandom;
            e  = ref_err(we, f3, a);
            ref_apply(we, f3, a, wd, rd);
            run("rand", we, f3, a, wd, rd, e, ref_lat(we, f3, a));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
